ddr_rd_arbiter: RTL and testbench

- Shares the single DDR read port between two requesters:
  - the Hit-stage database stream loader (sequential 512-bit database lines);
  - the Expand-stage loader (random-address fetches around a hit).
- Only one read is outstanding at a time. Expand has fixed priority over Hit, with a bounded-streak fairness rule.
- Includes a per-read timeout with automatic reissue.
- Sits between the search controller and the DDR read interface, replacing direct ddr_rd/readAdd driving.

---
 rtl/ddr_rd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// Shares the single DDR read port between the Hit and Expand loaders, one read in flight at a time.
// Latency: strobe on the grant edge, ack one cycle after valid&done is sampled; strobes >= 3 cycles apart.
// Backpressure: requesters hold req until their ack; a read with no response times out and is reissued.
module ddr_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_req,
    input  logic [ADDR_W-1:0] hit_addr,
    output logic              hit_ack,
    input  logic              exp_req,
    input  logic [ADDR_W-1:0] exp_addr,
    output logic              exp_ack,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] readAdd,
    input  logic              ddr_rd_valid,
    input  logic              ddr_rd_done,
    input  logic [DATA_W-1:0] ddr_rd_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_HIT = 1'b0,
        OWN_EXP = 1'b1
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [STK_W-1:0]   streak_q, streak_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               ddr_rd_q, ddr_rd_d;
    logic [ADDR_W-1:0]  read_add_q, read_add_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               hit_ack_q, hit_ack_d;
    logic               exp_ack_q, exp_ack_d;
    logic               timeout_err_q, timeout_err_d;

    logic grant_vld;
    logic grant_exp;
    logic streak_full;
    logic rd_complete;
    logic rd_expired;

    // Expand wins unless Hit has already been passed over MAX_STREAK times in a row.
    assign streak_full = (streak_q >= STK_MAX);
    assign grant_vld   = hit_req || exp_req;
    assign grant_exp   = exp_req && !(hit_req && streak_full);

    assign rd_complete = ddr_rd_valid && ddr_rd_done;
    assign rd_expired  = (wait_cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes precedence over a timeout on the same edge.
                if (rd_complete) begin
                    state_d = S_DONE;
                end else if (rd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ddr_rd_d      = 1'b0;
        hit_ack_d     = 1'b0;
        exp_ack_d     = 1'b0;
        read_add_d    = read_add_q;
        rsp_data_d    = rsp_data_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    ddr_rd_d   = 1'b1;
                    wait_cnt_d = '0;
                    if (grant_exp) begin
                        read_add_d = exp_addr;
                        owner_d    = OWN_EXP;
                        // An Expand grant over a waiting Hit implies the streak is below the cap.
                        streak_d   = hit_req ? (streak_q + STK_W'(1)) : '0;
                    end else begin
                        read_add_d = hit_addr;
                        owner_d    = OWN_HIT;
                        streak_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (rd_complete) begin
                    rsp_data_d = ddr_rd_data;
                    hit_ack_d  = (owner_q == OWN_HIT);
                    exp_ack_d  = (owner_q == OWN_EXP);
                end else if (rd_expired) begin
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q       <= OWN_HIT;
            streak_q      <= '0;
            wait_cnt_q    <= '0;
            ddr_rd_q      <= 1'b0;
            read_add_q    <= '0;
            rsp_data_q    <= '0;
            hit_ack_q     <= 1'b0;
            exp_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            streak_q      <= streak_d;
            wait_cnt_q    <= wait_cnt_d;
            ddr_rd_q      <= ddr_rd_d;
            read_add_q    <= read_add_d;
            rsp_data_q    <= rsp_data_d;
            hit_ack_q     <= hit_ack_d;
            exp_ack_q     <= exp_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ddr_rd      = ddr_rd_q;
    assign readAdd     = read_add_q;
    assign rsp_data    = rsp_data_q;
    assign hit_ack     = hit_ack_q;
    assign exp_ack     = exp_ack_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

    a_strobe_single: assert property (@(posedge clk) disable iff (!rst) ddr_rd |=> !ddr_rd);
    a_ack_onehot:    assert property (@(posedge clk) disable iff (!rst) !(hit_ack && exp_ack));
    a_ack_in_done:   assert property (@(posedge clk) disable iff (!rst) (hit_ack || exp_ack) |-> (state_q == S_DONE));

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Randomised bench for ddr_rd_arbiter: scenario tasks compare DUT behaviour with a request-level
// reference model (fixed priority with bounded streak, one read in flight, timeout reissue).
`timescale 1ns/1ps
module tb_ddr_rd_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 512;
    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 1023;

    logic              clk;
    logic              rst;
    logic              hit_req, exp_req;
    logic [ADDR_W-1:0] hit_addr, exp_addr;
    logic              hit_ack, exp_ack;
    logic [DATA_W-1:0] rsp_data;
    logic              ddr_rd;
    logic [ADDR_W-1:0] readAdd;
    logic              ddr_rd_valid, ddr_rd_done;
    logic [DATA_W-1:0] ddr_rd_data;
    logic              busy, timeout_err;

    // DDR inputs come either from the auto-responder or from the scenario task.
    logic              auto_rsp;
    logic              a_vld, m_vld, m_done;
    logic [DATA_W-1:0] a_dat, m_dat;
    int                rsp_lo, rsp_hi;
    logic [DATA_W-1:0] sent_q[$];
    logic [DATA_W-1:0] last_rsp;
    int                cyc;
    int                n_chk, n_pass;

    assign ddr_rd_valid = auto_rsp ? a_vld : m_vld;
    assign ddr_rd_done  = auto_rsp ? a_vld : m_done;
    assign ddr_rd_data  = auto_rsp ? a_dat : m_dat;

    ddr_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .hit_req(hit_req), .hit_addr(hit_addr), .hit_ack(hit_ack),
        .exp_req(exp_req), .exp_addr(exp_addr), .exp_ack(exp_ack),
        .rsp_data(rsp_data), .ddr_rd(ddr_rd), .readAdd(readAdd),
        .ddr_rd_valid(ddr_rd_valid), .ddr_rd_done(ddr_rd_done), .ddr_rd_data(ddr_rd_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr(input logic [3:0] region);
        logic [21:0] mid;
        mid = 22'($urandom);
        return {region, mid, 6'b0};
    endfunction

    // Auto-responder: answers each strobe with valid&done after a random delay.
    initial begin
        int cnt;
        cnt   = 0;
        a_vld = 1'b0;
        a_dat = '0;
        forever begin
            @(negedge clk);
            a_vld = 1'b0;
            if (!auto_rsp) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        a_dat = rand_line();
                        a_vld = 1'b1;
                        sent_q.push_back(a_dat);
                    end
                end
                if (ddr_rd) cnt = $urandom_range(rsp_hi, rsp_lo);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; hit_req = 1'b0; exp_req = 1'b0;
        m_vld = 1'b0; m_done = 1'b0; auto_rsp = 1'b0;
        sent_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_chk++; if (ddr_rd !== 1'b0) $display("FAIL reset_ddr_rd: got %b want 0", ddr_rd); else n_pass++;
        n_chk++; if (hit_ack !== 1'b0) $display("FAIL reset_hit_ack: got %b want 0", hit_ack); else n_pass++;
        n_chk++; if (exp_ack !== 1'b0) $display("FAIL reset_exp_ack: got %b want 0", exp_ack); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_chk++; if (readAdd !== '0) $display("FAIL reset_readAdd: got %h want 0", readAdd); else n_pass++;
        n_chk++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || ddr_rd !== 1'b0) $display("FAIL reset_idle_quiet: got busy=%b ddr_rd=%b want 0/0", busy, ddr_rd); else n_pass++;
    endtask

    task automatic test_single_hit();
        int s_cyc, a_cyc, n_strobe, n_hack, n_eack;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] a_data, want;
        apply_reset();
        rsp_lo = 5; rsp_hi = 5; auto_rsp = 1'b1;
        hit_addr = 32'h200; hit_req = 1'b1;
        s_cyc = -1; a_cyc = -1; n_strobe = 0; n_hack = 0; n_eack = 0; s_addr = '0; a_data = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ddr_rd) begin n_strobe++; s_cyc = cyc; s_addr = readAdd; end
            if (exp_ack) n_eack++;
            if (hit_ack) begin n_hack++; a_cyc = cyc; a_data = rsp_data; hit_req = 1'b0; end
        end
        want = (sent_q.size() > 0) ? sent_q[0] : '0;
        n_chk++; if (n_strobe != 1) $display("FAIL hit_strobe_cycles: got %0d want 1", n_strobe); else n_pass++;
        n_chk++; if (s_addr !== 32'h200) $display("FAIL hit_readAdd: got %h want 200", s_addr); else n_pass++;
        n_chk++; if (n_hack != 1) $display("FAIL hit_ack_cycles: got %0d want 1", n_hack); else n_pass++;
        n_chk++; if (n_eack != 0) $display("FAIL hit_no_exp_ack: got %0d want 0", n_eack); else n_pass++;
        n_chk++; if (a_cyc - s_cyc != 6) $display("FAIL hit_latency: got %0d want 6", a_cyc - s_cyc); else n_pass++;
        n_chk++; if (sent_q.size() == 0 || a_data !== want) $display("FAIL hit_rsp_data: got %h want %h", a_data, want); else n_pass++;
    endtask

    task automatic test_fairness();
        int streak, grants;
        bit want_exp, pend_exp;
        logic [DATA_W-1:0] want;
        apply_reset();
        rsp_lo = 1; rsp_hi = 6; auto_rsp = 1'b1;
        hit_addr = rand_addr(4'h1); exp_addr = rand_addr(4'h2);
        hit_req = 1'b1; exp_req = 1'b1;
        streak = 0; grants = 0; pend_exp = 1'b0;
        for (int i = 0; i < 400 && grants < 10; i++) begin
            @(negedge clk);
            if (ddr_rd) begin
                want_exp = (streak < MAX_STREAK);
                streak   = want_exp ? streak + 1 : 0;
                n_chk++; if (readAdd !== (want_exp ? exp_addr : hit_addr))
                    $display("FAIL fair_grant%0d: got readAdd=%h want %h (%s)", grants, readAdd,
                             want_exp ? exp_addr : hit_addr, want_exp ? "E" : "H");
                else n_pass++;
                pend_exp = want_exp;
                grants++;
            end
            if (hit_ack || exp_ack) begin
                want = (sent_q.size() > 0) ? sent_q.pop_front() : '0;
                n_chk++; if (exp_ack !== pend_exp || hit_ack !== !pend_exp || rsp_data !== want)
                    $display("FAIL fair_ack: got hit_ack=%b exp_ack=%b data=%h want exp=%b data=%h", hit_ack, exp_ack, rsp_data, pend_exp, want);
                else n_pass++;
                if (exp_ack) exp_addr = rand_addr(4'h2);
                if (hit_ack) hit_addr = rand_addr(4'h1);
            end
        end
        n_chk++; if (grants != 10) $display("FAIL fair_grant_count: got %0d want 10", grants); else n_pass++;
    endtask

    task automatic test_random();
        int streak, acks;
        bit want_exp, pend_exp;
        logic [DATA_W-1:0] want;
        apply_reset();
        rsp_lo = 1; rsp_hi = 8; auto_rsp = 1'b1;
        streak = 0; acks = 0; pend_exp = 1'b0;
        hit_addr = '0; exp_addr = '0;
        for (int i = 0; i < 3000 && acks < 40; i++) begin
            @(negedge clk);
            if (ddr_rd) begin
                want_exp = exp_req && (!hit_req || streak < MAX_STREAK);
                streak   = (want_exp && hit_req) ? streak + 1 : 0;
                n_chk++; if (readAdd !== (want_exp ? exp_addr : hit_addr))
                    $display("FAIL rand_grant: got readAdd=%h want %h (hit_req=%b exp_req=%b)", readAdd,
                             want_exp ? exp_addr : hit_addr, hit_req, exp_req);
                else n_pass++;
                pend_exp = want_exp;
            end
            if (hit_ack || exp_ack) begin
                want = (sent_q.size() > 0) ? sent_q.pop_front() : '0;
                n_chk++; if (exp_ack !== pend_exp || hit_ack !== !pend_exp || rsp_data !== want)
                    $display("FAIL rand_ack: got hit_ack=%b exp_ack=%b data=%h want exp=%b data=%h", hit_ack, exp_ack, rsp_data, pend_exp, want);
                else n_pass++;
                acks++;
                if (hit_ack) hit_req = 1'b0; else exp_req = 1'b0;
            end else begin
                if (!hit_req && $urandom_range(2, 0) == 0) begin hit_req = 1'b1; hit_addr = rand_addr(4'h3); end
                if (!exp_req && $urandom_range(2, 0) == 0) begin exp_req = 1'b1; exp_addr = rand_addr(4'h4); end
            end
        end
        n_chk++; if (acks != 40) $display("FAIL rand_ack_count: got %0d want 40", acks); else n_pass++;
    endtask

    task automatic test_timeout();
        int s1, s2, te_rise, n_ack, n_eack, n_hack;
        logic [ADDR_W-1:0] a1, a2, addr;
        logic te_at_s1;
        logic [DATA_W-1:0] got;
        apply_reset();
        addr = rand_addr(4'h5);
        exp_addr = addr; exp_req = 1'b1;
        s1 = -1; s2 = -1; te_rise = -1; n_ack = 0; a1 = '0; a2 = '0; te_at_s1 = 1'bx;
        for (int i = 0; i < TIMEOUT + 50 && s2 < 0; i++) begin
            @(negedge clk);
            if (ddr_rd) begin
                if (s1 < 0) begin s1 = cyc; a1 = readAdd; te_at_s1 = timeout_err; end
                else begin s2 = cyc; a2 = readAdd; end
            end
            if (timeout_err && te_rise < 0) te_rise = cyc;
            if (hit_ack || exp_ack) n_ack++;
        end
        n_chk++; if (te_at_s1 !== 1'b0) $display("FAIL to_err_before: got %b want 0", te_at_s1); else n_pass++;
        n_chk++; if (te_rise - s1 != TIMEOUT) $display("FAIL to_err_cycle: got %0d want %0d", te_rise - s1, TIMEOUT); else n_pass++;
        n_chk++; if (s2 < 0 || s2 - s1 != TIMEOUT + 1) $display("FAIL to_reissue_gap: got %0d want %0d", s2 - s1, TIMEOUT + 1); else n_pass++;
        n_chk++; if (a1 !== addr || a2 !== addr) $display("FAIL to_reissue_addr: got %h/%h want %h", a1, a2, addr); else n_pass++;
        n_chk++; if (n_ack != 0) $display("FAIL to_no_ack: got %0d want 0", n_ack); else n_pass++;
        m_dat = rand_line(); m_vld = 1'b1; m_done = 1'b1;
        @(negedge clk);
        m_vld = 1'b0; m_done = 1'b0;
        n_eack = 0; n_hack = 0; got = '0;
        for (int i = 0; i < 5; i++) begin
            if (exp_ack) begin n_eack++; got = rsp_data; exp_req = 1'b0; end
            if (hit_ack) n_hack++;
            @(negedge clk);
        end
        n_chk++; if (n_eack != 1 || n_hack != 0) $display("FAIL to_second_ack: got exp=%0d hit=%0d want 1/0", n_eack, n_hack); else n_pass++;
        n_chk++; if (got !== m_dat) $display("FAIL to_second_data: got %h want %h", got, m_dat); else n_pass++;
        n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", timeout_err); else n_pass++;
    endtask

    task automatic test_valid_no_done();
        bit found;
        int n_hack, n_eack, n_strobe;
        logic [DATA_W-1:0] final_dat, got;
        apply_reset();
        hit_addr = rand_addr(4'h6); hit_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ddr_rd) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL vnd_strobe: got none want strobe"); else n_pass++;
        n_hack = 0; n_eack = 0; n_strobe = 0; got = '0; final_dat = rand_line();
        for (int k = 0; k < 10; k++) begin
            if (k > 0 && ddr_rd) n_strobe++;
            if (exp_ack) n_eack++;
            if (hit_ack) begin n_hack++; got = rsp_data; hit_req = 1'b0; end
            if (k < 3) begin m_vld = 1'b1; m_done = 1'b0; m_dat = rand_line(); end
            else if (k == 3) begin m_vld = 1'b1; m_done = 1'b1; m_dat = final_dat; end
            else begin m_vld = 1'b0; m_done = 1'b0; end
            @(negedge clk);
        end
        n_chk++; if (n_hack != 1 || n_eack != 0) $display("FAIL vnd_ack_count: got hit=%0d exp=%0d want 1/0", n_hack, n_eack); else n_pass++;
        n_chk++; if (got !== final_dat) $display("FAIL vnd_data: got %h want %h", got, final_dat); else n_pass++;
        n_chk++; if (n_strobe != 0) $display("FAIL vnd_extra_strobe: got %0d want 0", n_strobe); else n_pass++;
        last_rsp = final_dat;
    endtask

    task automatic test_spurious();
        int n_ack, n_strobe, n_busy;
        n_ack = 0; n_strobe = 0; n_busy = 0;
        for (int k = 0; k < 8; k++) begin
            if (hit_ack || exp_ack) n_ack++;
            if (ddr_rd) n_strobe++;
            if (busy) n_busy++;
            if (k == 2) begin m_vld = 1'b1; m_done = 1'b1; m_dat = rand_line(); end
            else begin m_vld = 1'b0; m_done = 1'b0; end
            @(negedge clk);
        end
        n_chk++; if (n_ack != 0) $display("FAIL spur_ack: got %0d want 0", n_ack); else n_pass++;
        n_chk++; if (rsp_data !== last_rsp) $display("FAIL spur_rsp_data: got %h want %h", rsp_data, last_rsp); else n_pass++;
        n_chk++; if (n_strobe != 0 || n_busy != 0) $display("FAIL spur_idle: got strobe=%0d busy=%0d want 0/0", n_strobe, n_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit found;
        int n_ack;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] got, fresh;
        apply_reset();
        addr = rand_addr(4'h7);
        exp_addr = addr; exp_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ddr_rd) found = 1'b1;
        end
        #1 rst = 1'b0;
        #1;
        n_chk++; if (!found || ddr_rd !== 1'b0 || busy !== 1'b0 || readAdd !== '0)
            $display("FAIL rst_mid_outputs: got found=%b ddr_rd=%b busy=%b readAdd=%h want 1/0/0/0", found, ddr_rd, busy, readAdd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1; m_vld = 1'b1; m_done = 1'b1; m_dat = rand_line();
        @(negedge clk);
        m_vld = 1'b0; m_done = 1'b0;
        n_chk++; if (ddr_rd !== 1'b1 || readAdd !== addr) $display("FAIL rst_reissue: got ddr_rd=%b readAdd=%h want 1/%h", ddr_rd, readAdd, addr); else n_pass++;
        n_chk++; if (rsp_data !== '0) $display("FAIL rst_stale_ignored: got %h want 0", rsp_data); else n_pass++;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hit_ack || exp_ack) n_ack++;
        end
        n_chk++; if (n_ack != 0) $display("FAIL rst_no_ack: got %0d want 0", n_ack); else n_pass++;
        fresh = rand_line(); m_dat = fresh; m_vld = 1'b1; m_done = 1'b1;
        @(negedge clk);
        m_vld = 1'b0; m_done = 1'b0;
        n_ack = 0; got = '0;
        for (int i = 0; i < 5; i++) begin
            if (exp_ack) begin n_ack++; got = rsp_data; exp_req = 1'b0; end
            @(negedge clk);
        end
        n_chk++; if (n_ack != 1 || got !== fresh) $display("FAIL rst_fresh_ack: got acks=%0d data=%h want 1/%h", n_ack, got, fresh); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; hit_req = 1'b0; exp_req = 1'b0; hit_addr = '0; exp_addr = '0;
        auto_rsp = 1'b0; m_vld = 1'b0; m_done = 1'b0; m_dat = '0;
        rsp_lo = 1; rsp_hi = 1; last_rsp = '0;
        test_reset();
        test_single_hit();
        test_fairness();
        test_random();
        test_timeout();
        test_valid_no_done();
        test_spurious();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
